// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch feeding a 2-entry instruction queue.
// Optional misaligned-redirect detection is compiled in with FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misaligned
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_next;
    logic [31:0] r_rsp_pc;
    logic [31:0] w_rsp_pc_next;
    logic [1:0]  r_out_cnt;
    logic [1:0]  w_out_cnt_next;
    logic [1:0]  r_drop_cnt;
    logic [1:0]  w_drop_cnt_next;
    logic [1:0]  r_q_cnt;
    logic [1:0]  w_q_cnt_next;
    logic        r_q_head;
    logic        w_q_head_next;
    logic        r_misaligned;
    logic        w_misaligned_next;

    logic [31:0] r_q_data [QDEPTH];
    logic [31:0] r_q_pc   [QDEPTH];

    logic        w_redirect_run;
    logic        w_bad_target;
    logic [31:0] w_target;
    logic        w_pop;
    logic        w_push;
    logic        w_req_fire;
    logic        w_q_tail;
    logic [2:0]  w_credit;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_target     = redirect_pc;
    assign w_bad_target = (redirect_pc[1:0] != 2'b00);
`else
    assign w_target     = redirect_pc & 32'hFFFF_FFFC;
    assign w_bad_target = 1'b0;
`endif

    assign w_redirect_run = redirect && (r_state == ST_RUN);

    assign instr_valid = (r_q_cnt != 2'd0);
    assign instr       = r_q_data[r_q_head];
    assign instr_pc    = r_q_pc[r_q_head];
    assign misaligned  = r_misaligned;
    assign w_pop       = instr_valid && instr_ready;

    // The slot freed by this cycle's pop is already a credit, which keeps a
    // latency-1 memory streaming one instruction per cycle.
    assign w_credit = {1'b0, r_q_cnt} + {1'b0, r_out_cnt} - {2'b00, w_pop};

    assign imem_req_valid = rst_n && (r_state == ST_RUN) && !redirect && (w_credit < 3'd2);
    assign imem_addr      = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_push   = imem_rsp_valid && !w_redirect_run && (r_state == ST_RUN)
                      && (r_drop_cnt == 2'd0);
    assign w_q_tail = r_q_head ^ r_q_cnt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_fetch_pc_next   = r_fetch_pc;
        w_rsp_pc_next     = r_rsp_pc;
        w_out_cnt_next    = r_out_cnt + {1'b0, w_req_fire} - {1'b0, imem_rsp_valid};
        w_drop_cnt_next   = r_drop_cnt;
        w_q_cnt_next      = r_q_cnt;
        w_q_head_next     = r_q_head;
        w_misaligned_next = r_misaligned;
        if (w_redirect_run) begin
            // Everything still in flight after this cycle belongs to the old stream.
            w_fetch_pc_next = w_target;
            w_rsp_pc_next   = w_target;
            w_q_cnt_next    = 2'd0;
            w_q_head_next   = 1'b0;
            w_drop_cnt_next = r_out_cnt - {1'b0, imem_rsp_valid};
            if (w_bad_target) begin
                w_state_next      = ST_HALT;
                w_misaligned_next = 1'b1;
            end
        end else begin
            if (w_req_fire) begin
                w_fetch_pc_next = r_fetch_pc + 32'd4;
            end
            if (imem_rsp_valid && (r_drop_cnt != 2'd0)) begin
                w_drop_cnt_next = r_drop_cnt - 2'd1;
            end
            if (w_push) begin
                w_rsp_pc_next = r_rsp_pc + 32'd4;
            end
            w_q_cnt_next  = r_q_cnt + {1'b0, w_push} - {1'b0, w_pop};
            w_q_head_next = r_q_head ^ w_pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc   <= RESET_PC;
            r_rsp_pc     <= RESET_PC;
            r_out_cnt    <= 2'd0;
            r_drop_cnt   <= 2'd0;
            r_q_cnt      <= 2'd0;
            r_q_head     <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_fetch_pc   <= w_fetch_pc_next;
            r_rsp_pc     <= w_rsp_pc_next;
            r_out_cnt    <= w_out_cnt_next;
            r_drop_cnt   <= w_drop_cnt_next;
            r_q_cnt      <= w_q_cnt_next;
            r_q_head     <= w_q_head_next;
            r_misaligned <= w_misaligned_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_data[i] <= 32'd0;
                r_q_pc[i]   <= 32'd0;
            end
        end else if (w_push) begin
            r_q_data[w_q_tail] <= imem_rsp_data;
            r_q_pc[w_q_tail]   <= r_rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a variable-latency
// in-order instruction memory model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b1;
    logic        redirect       = 1'b0;
    logic [31:0] redirect_pc    = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'd0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: in order, per-request latency in [lat_min, lat_max].
    typedef struct packed {
        int          due;
        logic [31:0] data;
    } mreq_t;

    mreq_t mq[$];
    int    cyc     = 0;
    int    lat_min = 1;
    int    lat_max = 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'd0;
        end else begin
            cyc++;
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{due: cyc + int'($urandom_range(lat_max, lat_min)) - 1,
                               data: memfn(imem_addr)});
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mq[0].data;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Scoreboard: expected {instr, pc} pushed on each request accept, popped on delivery.
    logic [63:0] sb[$];
    logic [63:0] sb_exp;
    logic [31:0] exp_req_addr = RESET_PC;
    logic [31:0] last_pc      = 32'd0;
    int          n_deliv      = 0;
    bit          tb_halt      = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_req_addr = RESET_PC;
            tb_halt      = 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL deliver_unexpected got pc=%h instr=%h, none expected", instr_pc, instr);
                end else begin
                    sb_exp = sb.pop_front();
                    if ({instr, instr_pc} !== sb_exp) begin
                        failures++;
                        $display("FAIL deliver got pc=%h instr=%h expected pc=%h instr=%h",
                                 instr_pc, instr, sb_exp[31:0], sb_exp[63:32]);
                    end
                end
                n_deliv++;
                last_pc = instr_pc;
            end
            if (redirect && !tb_halt) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL redirect_no_req got req_valid=%b expected 0", imem_req_valid);
                end
                sb.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirect_pc[1:0] != 2'b00) tb_halt = 1'b1;
                exp_req_addr = redirect_pc;
`else
                exp_req_addr = {redirect_pc[31:2], 2'b00};
`endif
            end else if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (imem_addr !== exp_req_addr) begin
                    failures++;
                    $display("FAIL req_addr got %h expected %h", imem_addr, exp_req_addr);
                end
                sb.push_back({memfn(exp_req_addr), exp_req_addr});
                exp_req_addr = exp_req_addr + 32'd4;
            end
            if (tb_halt) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL halt_no_req got req_valid=%b expected 0", imem_req_valid);
                end
            end
            checks++;
            if (sb.size() > 2) begin
                failures++;
                $display("FAIL credit got %0d in flight+queued expected <=2", sb.size());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_deliv(output bit got, output logic [31:0] pc);
        int n0;
        int k;
        n0 = n_deliv;
        k  = 0;
        while (n_deliv == n0 && k < 40) begin
            tick(1);
            k++;
        end
        got = (n_deliv != n0);
        pc  = last_pc;
    endtask

    task automatic test_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_instr_valid got %b expected 0", instr_valid); end
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got %b expected 0", imem_req_valid); end
        checks++;
        if (misaligned !== 1'b0) begin failures++; $display("FAIL rst_misaligned got %b expected 0", misaligned); end
        checks++;
        if (instr !== 32'd0 || instr_pc !== 32'd0) begin
            failures++; $display("FAIL rst_instr got %h/%h expected 0/0", instr, instr_pc);
        end
        tick(1);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL first_req got valid=%b addr=%h expected 1/%h", imem_req_valid, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int n0;
        lat_min = 1; lat_max = 1;
        tick(4);
        n0 = n_deliv;
        tick(16);
        checks++;
        if (n_deliv - n0 != 16) begin
            failures++; $display("FAIL throughput got %0d delivered expected 16", n_deliv - n0);
        end
    endtask

    task automatic test_backpressure();
        int n_req;
        int n0;
        instr_ready = 1'b0;
        tick(4);
        n_req = 0;
        repeat (6) begin
            tick(1);
            if (imem_req_valid) n_req++;
        end
        checks++;
        if (n_req != 0) begin failures++; $display("FAIL stall_no_req got %0d req cycles expected 0", n_req); end
        checks++;
        if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got %b expected 1", instr_valid); end
        n0 = n_deliv;
        instr_ready = 1'b1;
        tick(6);
        checks++;
        if (n_deliv - n0 < 2) begin failures++; $display("FAIL stall_release got %0d delivered expected >=2", n_deliv - n0); end
    endtask

    task automatic test_redirect();
        bit          got;
        logic [31:0] pc;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        tick(4);
        lat_min = 3; lat_max = 3;
        imem_req_ready = 1'b1;
        tick(2);
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL two_outstanding got req_valid=%b instr_valid=%b expected 0/0", imem_req_valid, instr_valid);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick(1);
        redirect = 1'b0;
        wait_deliv(got, pc);
        checks++;
        if (!got || pc !== 32'h100) begin failures++; $display("FAIL redir_first got=%b pc=%h expected pc=00000100", got, pc); end
        wait_deliv(got, pc);
        checks++;
        if (!got || pc !== 32'h104) begin failures++; $display("FAIL redir_second got=%b pc=%h expected pc=00000104", got, pc); end
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_back_to_back();
        bit          got;
        logic [31:0] pc;
        tick(3);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick(1);
        redirect_pc = 32'h0000_0300;
        tick(1);
        redirect = 1'b0;
        wait_deliv(got, pc);
        checks++;
        if (!got || pc !== 32'h300) begin failures++; $display("FAIL b2b_redirect got=%b pc=%h expected pc=00000300", got, pc); end
    endtask

    task automatic test_wrap();
        bit          got;
        logic [31:0] pc;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        wait_deliv(got, pc);
        checks++;
        if (!got || pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first got=%b pc=%h expected FFFFFFFC", got, pc); end
        wait_deliv(got, pc);
        checks++;
        if (!got || pc !== 32'h0) begin failures++; $display("FAIL wrap_next got=%b pc=%h expected 00000000", got, pc); end
    endtask

    task automatic test_random();
        int n0;
        n0 = n_deliv;
        lat_min = 1; lat_max = 3;
        repeat (300) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready    = ($urandom_range(3, 0) != 0);
            if ($urandom_range(19, 0) == 0) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0000_1000 + (32'($urandom_range(63, 0)) << 2);
            end else begin
                redirect = 1'b0;
            end
            tick(1);
        end
        redirect = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        lat_min = 1; lat_max = 1;
        tick(8);
        checks++;
        if (n_deliv - n0 < 50) begin failures++; $display("FAIL random_progress got %0d delivered expected >=50", n_deliv - n0); end
    endtask

    task automatic test_misalign();
        bit          got;
        logic [31:0] pc;
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        tick(1);
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        begin
            int n_req;
            n_req = 0;
            repeat (10) begin
                tick(1);
                if (imem_req_valid) n_req++;
            end
            checks++;
            if (misaligned !== 1'b1) begin failures++; $display("FAIL misaligned_set got %b expected 1", misaligned); end
            checks++;
            if (n_req != 0 || instr_valid !== 1'b0) begin
                failures++; $display("FAIL halt got %0d req cycles valid=%b expected 0/0", n_req, instr_valid);
            end
            rst_n = 1'b0;
            tick(1);
            rst_n = 1'b1;
            tick(2);
            checks++;
            if (misaligned !== 1'b0) begin failures++; $display("FAIL misaligned_clear got %b expected 0", misaligned); end
        end
`else
        wait_deliv(got, pc);
        checks++;
        if (!got || pc !== 32'h100) begin failures++; $display("FAIL misalign_masked got=%b pc=%h expected 00000100", got, pc); end
        checks++;
        if (misaligned !== 1'b0) begin failures++; $display("FAIL misaligned_tied got %b expected 0", misaligned); end
`endif
    endtask

    task automatic test_reset_midstream();
        bit          got;
        logic [31:0] pc;
        instr_ready = 1'b0;
        tick(5);
        checks++;
        if (instr_valid !== 1'b1) begin failures++; $display("FAIL full_before_rst got %b expected 1", instr_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_rst got instr_valid=%b req_valid=%b expected 0/0", instr_valid, imem_req_valid);
        end
        tick(1);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        wait_deliv(got, pc);
        checks++;
        if (!got || pc !== RESET_PC) begin failures++; $display("FAIL restart got=%b pc=%h expected %h", got, pc, RESET_PC); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_random();
        test_misalign();
        test_reset_midstream();
        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
